fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 16'h6F0F, meaning the pipeline bubble injected on flush or idle.
REQ-002 SHALL have parameter PROG_STRIDE, default 100, meaning the address spacing between test programs.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin the program selected by prog_sel.
REQ-006 SHALL have port prog_sel  input  4  program number; 1..9 valid.
REQ-007 SHALL have port stall  input  1  hazard hold from decode.
REQ-008 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-009 SHALL have port branch_target  input  16  redirect address.
REQ-010 SHALL have port M_instruction  input  16  combinational instruction-memory read data for PCAdd_pc.
REQ-011 SHALL have port PCAdd_pc  output  16  instruction-memory fetch address.
REQ-012 SHALL have port IF_instruction  output  16  IF/ID register instruction.
REQ-013 SHALL have port IF_pc  output  16  address of IF_instruction.
REQ-014 SHALL have port IF_valid  output  1  IF_instruction is a real fetched instruction.
REQ-015 SHALL have port busy  output  1  high in RUN.
REQ-016 SHALL have port done  output  1  high in DONE.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-018 In IDLE or DONE, start with prog_sel in 1..9 SHALL load PCAdd_pc <= prog_sel*PROG_STRIDE, IF_instruction <= NOP_INSTR, IF_valid <= 0, and enter RUN next cycle.
REQ-019 start with prog_sel 0 or 10..15 SHALL be ignored (no state or output change); start while in RUN SHALL be ignored.
REQ-020 In RUN, with stall=0 and branch_taken=0: IF_instruction <= M_instruction, IF_pc <= PCAdd_pc, IF_valid <= 1, PCAdd_pc <= PCAdd_pc+1 each cycle (one-cycle fetch latency).
REQ-021 In RUN, stall=1 and branch_taken=0 SHALL hold PCAdd_pc, IF_instruction, IF_pc, IF_valid unchanged.
REQ-022 In RUN, branch_taken=1 SHALL have priority over stall and halt detection: PCAdd_pc <= {4'b0, branch_target[11:0]}, IF_instruction <= NOP_INSTR, IF_valid <= 0, IF_pc unchanged.
REQ-023 Halt: in RUN, no stall/branch, M_instruction[15:12]==4'b0001 SHALL be latched as a normal fetch (REQ-020) but PCAdd_pc SHALL hold and state SHALL go DONE.
REQ-024 In DONE, IF_instruction <= NOP_INSTR and IF_valid <= 0 every cycle; PCAdd_pc and IF_pc hold.
REQ-025 In IDLE, IF_instruction = NOP_INSTR, IF_valid = 0, PCAdd_pc holds.
REQ-026 PCAdd_pc[15:12] SHALL always be 0; increment from 4095 SHALL wrap to 0 and stay in RUN.
REQ-027 stall and branch_taken SHALL be ignored outside RUN.

Reset
REQ-028 reset=1 at a clock edge SHALL force state IDLE, PCAdd_pc=0, IF_pc=0, IF_instruction=NOP_INSTR, IF_valid=0, busy=0, done=0, overriding all other inputs, including mid-RUN and coincident start.
REQ-029 The first start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-030 reset, then start with prog_sel=1 -> PCAdd_pc=100 next cycle, busy=1; following cycles IF_pc=100,101,... IF_valid=1.
REQ-031 Program 1 memory image (105 has opcode 0001) -> IF_pc=105 latched, PCAdd_pc holds 105, done=1, then IF_instruction=16'h6F0F, IF_valid=0.
REQ-032 stall=1 for 3 cycles at PCAdd_pc=202 -> PCAdd_pc, IF_pc, IF_instruction constant 3 cycles, resume at 203 with no skipped or duplicated fetch.
REQ-033 branch_taken=1 with stall=1, branch_target=16'hF320 -> PCAdd_pc=16'h0320, IF_valid=0, IF_instruction=16'h6F0F.
REQ-034 start with prog_sel=0 and 12 in IDLE -> no change; start with prog_sel=5 during RUN -> ignored.
REQ-035 branch to 4095 with non-halt instruction -> next PCAdd_pc=0; reset asserted mid-RUN -> all outputs at REQ-028 values next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program launch, sequential fetch with stall/branch
// handling, and halt detection feeding the IF/ID register.
module fetch_stage #(
   parameter logic [15:0] NOP_INSTR   = 16'h6F0F,
   parameter int          PROG_STRIDE = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  prog_sel,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic [15:0] M_instruction,
   output logic [15:0] PCAdd_pc,
   output logic [15:0] IF_instruction,
   output logic [15:0] IF_pc,
   output logic        IF_valid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // The fetch address space is 12 bits; the top nibble is always zero.
   localparam logic [15:0] ADDR_MASK = 16'h0FFF;

   state_t state;
   logic   start_ok;
   logic   halt;

   function automatic logic [15:0] prog_base(input logic [3:0] sel);
      return (16'(sel) * 16'(PROG_STRIDE)) & ADDR_MASK;
   endfunction

   function automatic logic [15:0] next_addr(input logic [15:0] addr);
      return (addr + 16'd1) & ADDR_MASK;
   endfunction

   assign start_ok = start && (prog_sel >= 4'd1) && (prog_sel <= 4'd9);
   assign halt     = (M_instruction[15:12] == 4'b0001);

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         PCAdd_pc       <= 16'd0;
         IF_pc          <= 16'd0;
         IF_instruction <= NOP_INSTR;
         IF_valid       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               // A taken branch wins over both stall and a halt in the fetch slot.
               if (branch_taken) begin
                  PCAdd_pc       <= branch_target & ADDR_MASK;
                  IF_instruction <= NOP_INSTR;
                  IF_valid       <= 1'b0;
               end else if (!stall) begin
                  IF_instruction <= M_instruction;
                  IF_pc          <= PCAdd_pc;
                  IF_valid       <= 1'b1;
                  if (halt) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     PCAdd_pc <= next_addr(PCAdd_pc);
                  end
               end
            end
            IDLE, DONE: begin
               IF_instruction <= NOP_INSTR;
               IF_valid       <= 1'b0;
               if (start_ok) begin
                  PCAdd_pc <= prog_base(prog_sel);
                  state    <= RUN;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
